writeback_23rv: RTL and testbench
=================================

WRITEBACK_23RV -- requirements
Module: writeback_23rv

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_WIDTH, 32, width of result and write data.
REQ-002 The block SHALL have parameter ADDRESS_BITWIDTH, 5, width of destination register index.
REQ-003 The block SHALL have parameter DEPTH, 2, number of entries in the writeback queue (power of two, >=2).
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
REQ-006 The block SHALL have port in_valid, input, 1, upstream result valid.
REQ-007 The block SHALL have port in_ready, output, 1, queue can accept this cycle.
REQ-008 The block SHALL have port in_rd, input, ADDRESS_BITWIDTH, destination register index.
REQ-009 The block SHALL have port in_sel, input, 2, source select: 0 ALU, 1 LOAD, 2 LINK (pc+4), 3 NONE.
REQ-010 The block SHALL have port in_alu, input, DATA_WIDTH, ALU result.
REQ-011 The block SHALL have port in_pc, input, DATA_WIDTH, instruction PC.
REQ-012 The block SHALL have port in_mem, input, DATA_WIDTH, raw aligned load word.
REQ-013 The block SHALL have port in_funct3, input, 3, load type (RV32I encoding).
REQ-014 The block SHALL have port in_addr_lo, input, 2, load byte offset.
REQ-015 The block SHALL have port wb_stall, input, 1, regfile write port unavailable this cycle.
REQ-016 The block SHALL have port rd, output, ADDRESS_BITWIDTH, regfile write index.
REQ-017 The block SHALL have port wd, output, DATA_WIDTH, regfile write data.
REQ-018 The block SHALL have port we, output, 1, regfile write enable.
REQ-019 The block SHALL have port load_err, output, 1, one-cycle pulse on illegal/misaligned load.
REQ-020 The block SHALL have port retire_count, output, 16, count of entries popped; wraps at 0xFFFF->0.

Function
REQ-021 The block SHALL push an entry at a rising edge when in_valid && in_ready; in_ready = !full (no push-while-full bypass).
REQ-022 The block SHALL compute write data at push time and store {rd, data, write_flag}: ALU -> in_alu; LINK -> in_pc+4 mod 2^DATA_WIDTH; NONE -> write_flag=0.
REQ-023 For LOAD, the block SHALL extract: LB/LBU (000/100) byte at in_addr_lo, sign/zero-extended; LH/LHU (001/101) halfword at in_addr_lo[1], sign/zero-extended; LW (010) full word.
REQ-024 For LOAD with LH/LHU and in_addr_lo[0]=1, LW and in_addr_lo!=0, or funct3 in {011,110,111}, the block SHALL store write_flag=0 and pulse load_err high for the cycle following the push edge.
REQ-025 The block SHALL force write_flag=0 whenever in_rd==0 (x0 never written).
REQ-026 The block SHALL drive rd/wd combinationally from the queue head; we = !empty && !wb_stall && head.write_flag.
REQ-027 The block SHALL pop the head at a rising edge when !empty && !wb_stall, regardless of write_flag; retire_count increments by 1 per pop.
REQ-028 Latency: an entry pushed at edge N SHALL present we at cycle N+1 when the queue was empty and wb_stall=0; regfile write completes at edge N+1.
REQ-029 Simultaneous push and pop SHALL both take effect in the same edge; occupancy unchanged; order strictly FIFO.
REQ-030 When empty, the block SHALL drive rd=0, wd=0, we=0.
REQ-031 Pointers SHALL wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.

Reset
REQ-032 While reset=0, the block SHALL hold queue empty, in_ready=1, rd=0, wd=0, we=0, load_err=0, retire_count=0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries without issuing any further we.
REQ-034 After reset deasserts, the first push SHALL be accepted at the next rising edge.

Verification
REQ-035 ALU push rd=5, in_alu=0x0000_0032, wb_stall=0 -> next cycle we=1, rd=5, wd=0x32; retire_count=1 after pop.
REQ-036 LOAD LB in_mem=0x80FF_7F01, addr_lo=3 -> wd=0xFFFF_FF80; LBU addr_lo=1 -> wd=0x0000_007F; LH addr_lo=2 -> wd=0xFFFF_80FF.
REQ-037 LW addr_lo=2 rd=7 -> we never asserted for entry, load_err=1 for one cycle, retire_count still increments.
REQ-038 wb_stall=1, push 3 entries (rd=1,2,3) -> third blocked (in_ready=0 after two); release stall -> writes rd=1,2,3 on consecutive cycles.
REQ-039 LINK push in_pc=0xFFFF_FFFC rd=1 -> wd=0x0000_0000; ALU push rd=0 in_alu=0x1234 -> we stays 0.
REQ-040 Two entries queued, reset pulsed low mid-cycle -> outputs zero immediately, no we afterwards, retire_count=0.

Source files
------------

// File: rtl/writeback_23rv.sv
// writeback_23rv: in-order writeback queue between the execute/memory stage
// and the register file. Write data is formed when an entry is pushed:
// ALU result, load extraction, or link address. The queue head drives the
// regfile write port directly, and the head retires whenever the port is free.
module writeback_23rv #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITWIDTH = 5,
  parameter int DEPTH            = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDRESS_BITWIDTH-1:0] in_rd,
  input  logic [1:0]                  in_sel,
  input  logic [DATA_WIDTH-1:0]       in_alu,
  input  logic [DATA_WIDTH-1:0]       in_pc,
  input  logic [DATA_WIDTH-1:0]       in_mem,
  input  logic [2:0]                  in_funct3,
  input  logic [1:0]                  in_addr_lo,
  input  logic                        wb_stall,
  output logic [ADDRESS_BITWIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]       wd,
  output logic                        we,
  output logic                        load_err,
  output logic [15:0]                 retire_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_LINK = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Queue storage: one {rd, data, write_flag} tuple per slot
  logic [ADDRESS_BITWIDTH-1:0] rd_mem_r   [DEPTH];
  logic [DATA_WIDTH-1:0]       data_mem_r [DEPTH];
  logic                        flag_mem_r [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             load_err_r;
  logic [15:0]      retire_count_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [7:0]            byte_s;
  logic [15:0]           half_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic                  load_bad_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic                  push_flag_s;
  logic                  push_err_s;
  logic                  entry_flag_s;

  assign empty_s = (count_r == {(PTR_W+1){1'b0}});
  assign full_s  = (count_r == FULL_COUNT);
  assign push_s  = in_valid && !full_s;
  assign pop_s   = !empty_s && !wb_stall;

  // Select the addressed byte and halfword of the raw load word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (in_addr_lo)
      2'd0:    byte_s = in_mem[7:0];
      2'd1:    byte_s = in_mem[15:8];
      2'd2:    byte_s = in_mem[23:16];
      default: byte_s = in_mem[31:24];
    endcase
    if (in_addr_lo[1]) begin
      half_s = in_mem[31:16];
    end else begin
      half_s = in_mem[15:0];
    end
  end

  // Extend the load by funct3 and flag misaligned or unknown load types
  always_comb begin
    load_data_s = {DATA_WIDTH{1'b0}};
    load_bad_s  = 1'b0;
    case (in_funct3)
      F3_LB:  load_data_s = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      F3_LBU: load_data_s = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      F3_LH: begin
        if (in_addr_lo[0]) begin
          load_bad_s = 1'b1;
        end else begin
          load_data_s = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
        end
      end
      F3_LHU: begin
        if (in_addr_lo[0]) begin
          load_bad_s = 1'b1;
        end else begin
          load_data_s = {{(DATA_WIDTH-16){1'b0}}, half_s};
        end
      end
      F3_LW: begin
        if (in_addr_lo != 2'b00) begin
          load_bad_s = 1'b1;
        end else begin
          load_data_s = in_mem;
        end
      end
      default: load_bad_s = 1'b1;
    endcase
  end

  // Form the entry to be pushed; x0 is never written
  always_comb begin
    push_data_s = {DATA_WIDTH{1'b0}};
    push_flag_s = 1'b0;
    push_err_s  = 1'b0;
    case (in_sel)
      SEL_ALU: begin
        push_data_s = in_alu;
        push_flag_s = 1'b1;
      end
      SEL_LOAD: begin
        push_data_s = load_data_s;
        push_flag_s = !load_bad_s;
        push_err_s  = load_bad_s;
      end
      SEL_LINK: begin
        push_data_s = in_pc + DATA_WIDTH'(32'd4);
        push_flag_s = 1'b1;
      end
      default: begin
        push_flag_s = 1'b0;
      end
    endcase
    if (in_rd == {ADDRESS_BITWIDTH{1'b0}}) begin
      entry_flag_s = 1'b0;
    end else begin
      entry_flag_s = push_flag_s;
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= {ADDRESS_BITWIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
        flag_mem_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        rd_mem_r[wr_ptr_r]   <= in_rd;
        data_mem_r[wr_ptr_r] <= push_data_s;
        flag_mem_r[wr_ptr_r] <= entry_flag_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // One-cycle load error pulse following the push of a bad load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_err_r <= 1'b0;
    end else begin
      load_err_r <= push_s && push_err_s;
    end
  end

  // Count retired entries, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count_r <= 16'h0000;
    end else if (pop_s) begin
      retire_count_r <= retire_count_r + 16'd1;
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  // Regfile write port driven from the queue head, zero when empty
  always_comb begin
    if (empty_s) begin
      rd = {ADDRESS_BITWIDTH{1'b0}};
      wd = {DATA_WIDTH{1'b0}};
      we = 1'b0;
    end else begin
      rd = rd_mem_r[rd_ptr_r];
      wd = data_mem_r[rd_ptr_r];
      we = !wb_stall && flag_mem_r[rd_ptr_r];
    end
  end

  assign in_ready     = !full_s;
  assign load_err     = load_err_r;
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_writeback_23rv.sv
// Testbench for writeback_23rv: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_writeback_23rv;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [1:0]    in_sel;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_mem;
  logic [2:0]    in_funct3;
  logic [1:0]    in_addr_lo;
  logic          wb_stall;
  logic [AW-1:0] rd;
  logic [DW-1:0] wd;
  logic          we;
  logic          load_err;
  logic [15:0]   retire_count;

  writeback_23rv #(.DATA_WIDTH(DW), .ADDRESS_BITWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_pc(in_pc),
    .in_mem(in_mem), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .wb_stall(wb_stall), .rd(rd), .wd(wd), .we(we), .load_err(load_err),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          flag;
  } entry_t;

  entry_t      q[$];
  logic        exp_err = 1'b0;
  logic [15:0] exp_retire = 16'h0000;

  // Reference entry computed from the architectural load/link rules
  function automatic entry_t ref_entry(input logic [AW-1:0] r, input logic [1:0] sel,
                                       input logic [DW-1:0] alu, input logic [DW-1:0] pc,
                                       input logic [DW-1:0] mem, input logic [2:0] f3,
                                       input logic [1:0] lo, output logic err);
    entry_t e;
    longint unsigned v;
    e.rd = r; e.data = 32'h0; e.flag = 1'b0; err = 1'b0;
    v = longint'(mem) >> (8 * lo);
    if (sel == 2'd0) begin
      e.data = alu; e.flag = 1'b1;
    end else if (sel == 2'd2) begin
      e.data = DW'((longint'(pc) + 64'd4) % 64'h1_0000_0000); e.flag = 1'b1;
    end else if (sel == 2'd1) begin
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
        e.data = DW'(v); e.flag = 1'b1;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        if (lo % 2 == 1) err = 1'b1;
        else begin
          v = v % 65536;
          if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
          e.data = DW'(v); e.flag = 1'b1;
        end
      end else if (f3 == 3'd2) begin
        if (lo != 2'd0) err = 1'b1;
        else begin e.data = mem; e.flag = 1'b1; end
      end else begin
        err = 1'b1;
      end
    end
    if (r == 5'd0) e.flag = 1'b0;
    return e;
  endfunction

  // Advance one clock: update the model from the inputs held across the edge
  task automatic step();
    logic   push, pop, err;
    entry_t e, dummy;
    push = in_valid && (q.size() < DEPTH);
    pop  = (q.size() > 0) && !wb_stall;
    e = ref_entry(in_rd, in_sel, in_alu, in_pc, in_mem, in_funct3, in_addr_lo, err);
    @(posedge clk);
    if (pop) begin dummy = q.pop_front(); exp_retire = exp_retire + 16'd1; end
    if (push) q.push_back(e);
    exp_err = push && err && (in_sel == 2'd1);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] r, input logic [1:0] sel,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [2:0] f3, input logic [1:0] lo);
    in_valid = v; in_rd = r; in_sel = sel; in_alu = alu; in_mem = mem;
    in_funct3 = f3; in_addr_lo = lo;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_stall = 1'b0; in_pc = 32'h0;
    set_in(1'b0, 5'd0, 2'd3, 32'h0, 32'h0, 3'd0, 2'd0);
    #12;
    n_tests++;
    if ({in_ready, we, load_err} !== 3'b100 || rd !== 5'd0 || wd !== 32'h0 || retire_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b we=%b err=%b rd=%0d wd=%h rc=%0d, want 1 0 0 0 0 0",
               in_ready, we, load_err, rd, wd, retire_count);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    q.delete(); exp_retire = 16'h0; exp_err = 1'b0;
  endtask

  task automatic test_alu();
    set_in(1'b1, 5'd5, 2'd0, 32'h0000_0032, 32'h0, 3'd0, 2'd0);
    step();
    in_valid = 1'b0; #1;
    n_tests++;
    if (we !== 1'b1 || rd !== 5'd5 || wd !== 32'h32) begin
      n_fail++; $display("FAIL alu_write: got we=%b rd=%0d wd=%h, want 1 5 00000032", we, rd, wd);
    end
    step();
    n_tests++;
    if (retire_count !== 16'd1 || we !== 1'b0) begin
      n_fail++; $display("FAIL alu_retire: got rc=%0d we=%b, want 1 0", retire_count, we);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3s [3] = '{3'd0, 3'd4, 3'd1};
    logic [1:0]  los [3] = '{2'd3, 2'd1, 2'd2};
    logic [31:0] exps[3] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd9, 2'd1, 32'h0, 32'h80FF_7F01, f3s[i], los[i]);
      step();
      in_valid = 1'b0; #1;
      n_tests++;
      if (we !== 1'b1 || wd !== exps[i] || load_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_extract[%0d]: got we=%b wd=%h err=%b, want 1 %h 0", i, we, wd, load_err, exps[i]);
      end
      step();
    end
  endtask

  task automatic test_load_err();
    logic [15:0] rc0;
    rc0 = retire_count;
    set_in(1'b1, 5'd7, 2'd1, 32'h0, 32'h1234_5678, 3'd2, 2'd2);
    step();
    in_valid = 1'b0; #1;
    n_tests++;
    if (load_err !== 1'b1 || we !== 1'b0) begin
      n_fail++; $display("FAIL load_err_pulse: got err=%b we=%b, want 1 0", load_err, we);
    end
    step();
    n_tests++;
    if (load_err !== 1'b0 || we !== 1'b0 || retire_count !== rc0 + 16'd1) begin
      n_fail++;
      $display("FAIL load_err_retire: got err=%b we=%b rc=%0d, want 0 0 %0d", load_err, we, retire_count, rc0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] seen[$];
    wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 5'(i), 2'd0, 32'h100 + 32'(i), 32'h0, 3'd0, 2'd0);
      #1;
      if (i == 3) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL full_block: got in_ready=%b, want 0", in_ready);
        end
      end
      step();
    end
    wb_stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) in_valid = 1'b0;
      #1;
      if (we === 1'b1) seen.push_back(rd);
      else seen.push_back(5'd31);
      step();
    end
    n_tests++;
    if (seen.size() != 3 || seen[0] !== 5'd1 || seen[1] !== 5'd2 || seen[2] !== 5'd3) begin
      n_fail++; $display("FAIL drain_order: got %p, want 1 2 3 on consecutive cycles", seen);
    end
  endtask

  task automatic test_link_x0();
    logic [15:0] rc0;
    in_pc = 32'hFFFF_FFFC;
    set_in(1'b1, 5'd1, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0);
    step();
    set_in(1'b1, 5'd0, 2'd0, 32'h1234, 32'h0, 3'd0, 2'd0);
    #1;
    n_tests++;
    if (we !== 1'b1 || rd !== 5'd1 || wd !== 32'h0) begin
      n_fail++; $display("FAIL link_wrap: got we=%b rd=%0d wd=%h, want 1 1 00000000", we, rd, wd);
    end
    rc0 = retire_count;
    step();
    in_valid = 1'b0; #1;
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_write: got we=%b, want 0", we);
    end
    step();
    n_tests++;
    if (retire_count !== rc0 + 16'd2) begin
      n_fail++; $display("FAIL x0_retire: got rc=%0d, want %0d", retire_count, rc0 + 16'd2);
    end
  endtask

  task automatic test_random();
    entry_t h;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rd      = 5'($urandom_range(0, 31));
      in_sel     = 2'($urandom_range(0, 3));
      in_alu     = $urandom;
      in_pc      = $urandom;
      in_mem     = $urandom;
      in_funct3  = 3'($urandom_range(0, 7));
      in_addr_lo = 2'($urandom_range(0, 3));
      wb_stall   = ($urandom_range(0, 3) == 0);
      #1;
      n_tests++;
      if (in_ready !== (q.size() < DEPTH) || load_err !== exp_err || retire_count !== exp_retire) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: got ready=%b err=%b rc=%0d, want %b %b %0d",
                 c, in_ready, load_err, retire_count, q.size() < DEPTH, exp_err, exp_retire);
      end
      n_tests++;
      if (q.size() == 0) begin
        if (we !== 1'b0 || rd !== 5'd0 || wd !== 32'h0) begin
          n_fail++; $display("FAIL rand_empty[%0d]: got we=%b rd=%0d wd=%h, want 0 0 0", c, we, rd, wd);
        end
      end else begin
        h = q[0];
        if (we !== (h.flag && !wb_stall) || (h.flag && (rd !== h.rd || wd !== h.data))) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got we=%b rd=%0d wd=%h, want we=%b rd=%0d wd=%h",
                   c, we, rd, wd, h.flag && !wb_stall, h.rd, h.data);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int wes;
    wb_stall = 1'b1;
    set_in(1'b1, 5'd4, 2'd0, 32'hAAAA, 32'h0, 3'd0, 2'd0);
    step(); step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (we !== 1'b0 || rd !== 5'd0 || wd !== 32'h0 || in_ready !== 1'b1 || retire_count !== 16'h0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got we=%b rd=%0d wd=%h ready=%b rc=%0d err=%b, want 0 0 0 1 0 0",
               we, rd, wd, in_ready, retire_count, load_err);
    end
    q.delete(); exp_retire = 16'h0; exp_err = 1'b0;
    wb_stall = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    wes = 0;
    for (int c = 0; c < 3; c++) begin
      #1; if (we !== 1'b0) wes++;
      step();
    end
    n_tests++;
    if (wes != 0 || retire_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_discard: got we_cycles=%0d rc=%0d, want 0 0", wes, retire_count);
    end
    set_in(1'b1, 5'd6, 2'd0, 32'h55, 32'h0, 3'd0, 2'd0);
    step();
    in_valid = 1'b0; #1;
    n_tests++;
    if (we !== 1'b1 || rd !== 5'd6 || wd !== 32'h55) begin
      n_fail++; $display("FAIL reset_first_push: got we=%b rd=%0d wd=%h, want 1 6 00000055", we, rd, wd);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_load_err();
    test_back_to_back();
    test_link_x0();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
